// File: rtl/ram256_host_ctrl_if.sv
// ram256_host_ctrl_if
//   Host-side request/response channel of the RAM256 host controller.
//   Request:  req_valid/req_ready handshake carrying req_we (byte lanes,
//             4'h0 = read), req_addr (word address) and req_wdata.
//   Response: rsp_valid/rsp_ready handshake carrying rsp_rdata.
//   Modports: master = host / bus adapter side, slave = controller side.
interface ram256_host_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_we;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ram256_host_ctrl.sv
// ram256_host_ctrl
//   Initiator-side controller for a single RAM256 macro. Converts host
//   requests into RAM256 port strobes and returns read data on a response
//   channel. Writes complete in the accept cycle (1 per cycle); a read
//   returns rsp_valid two cycles after acceptance and is held until taken.
//
//   Optional clear engine, built only when RAM256_HOST_CTRL_CLR_EN is
//   defined: fills addresses 0..CLR_LAST with CLR_VALUE, one word per cycle.
//   Without the macro clr_start is ignored and clr_busy/clr_done stay 0.
//
// Ports:
//   CLK, RST   clock, synchronous active-high reset
//   host       request/response channel (slave modport)
//   clr_start  clear request pulse (sampled in IDLE only)
//   clr_busy   clear in progress
//   clr_done   one-cycle pulse after the last clear write
//   EN0/WE0/A0/Di0  RAM256 enable, byte write enables, address, write data
//   Do0        RAM256 read data, valid the cycle after a read strobe
module ram256_host_ctrl #(
    parameter logic [31:0] CLR_VALUE = 32'h0000_0000,
    parameter logic [7:0]  CLR_LAST  = 8'd255
) (
    input  logic                 CLK,
    input  logic                 RST,
    ram256_host_ctrl_if.slave    host,
    input  logic                 clr_start,
    output logic                 clr_busy,
    output logic                 clr_done,
    output logic                 EN0,
    output logic [3:0]           WE0,
    output logic [7:0]           A0,
    output logic [31:0]          Di0,
    input  logic [31:0]          Do0
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RSP     = 2'd2
`ifdef RAM256_HOST_CTRL_CLR_EN
        ,
        CLR     = 2'd3
`endif
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        accept;
    logic        clr_block;
    logic [31:0] rdata_q;

`ifdef RAM256_HOST_CTRL_CLR_EN
    logic [7:0]  clr_cnt;
    logic        clr_last_hit;
    logic        clr_done_q;

    // clr_start wins over a simultaneous request in IDLE
    assign clr_block    = clr_start;
    assign clr_last_hit = (state == CLR) && (clr_cnt == CLR_LAST);
`else
    logic        clr_unused;

    assign clr_block  = 1'b0;
    assign clr_unused = ^{clr_start, CLR_VALUE, CLR_LAST};
`endif

    assign host.req_ready = (state == IDLE) && !RST && !clr_block;
    assign accept         = host.req_valid && host.req_ready;

    // Gated with RST so a pending response vanishes in the reset cycle itself
    assign host.rsp_valid = (state == RSP) && !RST;
    assign host.rsp_rdata = rdata_q;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
`ifdef RAM256_HOST_CTRL_CLR_EN
                if (clr_start) begin
                    state_next = CLR;
                end else
`endif
                if (accept && (host.req_we == 4'h0)) begin
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: state_next = RSP;
            RSP: begin
                if (host.rsp_ready) begin
                    state_next = IDLE;
                end
            end
`ifdef RAM256_HOST_CTRL_CLR_EN
            CLR: begin
                if (clr_last_hit) begin
                    state_next = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // RAM port outputs: combinational from the accepted request or clear counter
    always_comb begin
        EN0 = 1'b0;
        WE0 = '0;
        A0  = '0;
        Di0 = '0;
        if (!RST) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        EN0 = 1'b1;
                        WE0 = host.req_we;
                        A0  = host.req_addr;
                        Di0 = host.req_wdata;
                    end
                end
`ifdef RAM256_HOST_CTRL_CLR_EN
                CLR: begin
                    EN0 = 1'b1;
                    WE0 = '1;
                    A0  = clr_cnt;
                    Di0 = CLR_VALUE;
                end
`endif
                default: ;
            endcase
        end
    end

    // Read data capture: Do0 is valid in RD_WAIT, held through RSP
    always_ff @(posedge CLK) begin
        if (RST) begin
            rdata_q <= '0;
        end else if (state == RD_WAIT) begin
            rdata_q <= Do0;
        end
    end

`ifdef RAM256_HOST_CTRL_CLR_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            clr_cnt    <= '0;
            clr_done_q <= 1'b0;
        end else begin
            clr_done_q <= clr_last_hit;
            if (clr_last_hit) begin
                clr_cnt <= '0;
            end else if (state == CLR) begin
                clr_cnt <= clr_cnt + 8'd1;
            end
        end
    end

    assign clr_busy = (state == CLR) && !RST;
    assign clr_done = clr_done_q;
`else
    assign clr_busy = 1'b0;
    assign clr_done = 1'b0;
`endif

endmodule

// File: tb/tb_ram256_host_ctrl.sv
// tb_ram256_host_ctrl
//   Directed testbench for ram256_host_ctrl with a behavioural RAM256 model
//   (byte-lane writes, read data registered one cycle after the strobe).
//   Clear-engine checks are built when RAM256_HOST_CTRL_CLR_EN is defined;
//   otherwise the bench checks that clr_start is ignored.
module tb_ram256_host_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        clr_start;
    logic        clr_busy;
    logic        clr_done;
    logic        EN0;
    logic [3:0]  WE0;
    logic [7:0]  A0;
    logic [31:0] Di0;
    logic [31:0] Do0;

    logic [31:0] mem [256];

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    ram256_host_ctrl_if host ();

    ram256_host_ctrl #(
        .CLR_VALUE (32'h5A5A_5A5A),
        .CLR_LAST  (8'd255)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .host      (host.slave),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .EN0       (EN0),
        .WE0       (WE0),
        .A0        (A0),
        .Di0       (Di0),
        .Do0       (Do0)
    );

    always #5 CLK = ~CLK;

    // RAM256 model
    always @(posedge CLK) begin
        if (EN0) begin
            for (int b = 0; b < 4; b++) begin
                if (WE0[b]) mem[A0][b*8 +: 8] <= Di0[b*8 +: 8];
            end
            if (WE0 == 4'h0) Do0 <= mem[A0];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] we);
        host.req_valid = 1'b1;
        host.req_we    = we;
        host.req_addr  = addr;
        host.req_wdata = data;
        settle();
        check("wr_en0", {31'd0, EN0}, 32'd1);
        step();
        host.req_valid = 1'b0;
        host.req_we    = 4'h0;
        settle();
    endtask

    task automatic do_read(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        host.req_valid = 1'b1;
        host.req_we    = 4'h0;
        host.req_addr  = addr;
        host.rsp_ready = 1'b1;
        settle();
        check({tag, "_en0"}, {31'd0, EN0}, 32'd1);
        check({tag, "_we0"}, {28'd0, WE0}, 32'd0);
        step();
        host.req_valid = 1'b0;
        settle();
        check({tag, "_t1_valid"}, {31'd0, host.rsp_valid}, 32'd0);
        step();
        settle();
        check({tag, "_t2_valid"}, {31'd0, host.rsp_valid}, 32'd1);
        check({tag, "_rdata"}, host.rsp_rdata, exp);
        step();
        host.rsp_ready = 1'b0;
        settle();
        check({tag, "_done_valid"}, {31'd0, host.rsp_valid}, 32'd0);
        check({tag, "_ready_after"}, {31'd0, host.req_ready}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        Do0            = 32'h0;
        RST            = 1'b1;
        clr_start      = 1'b0;
        host.req_valid = 1'b1;
        host.req_we    = 4'hF;
        host.req_addr  = 8'h12;
        host.req_wdata = 32'h1111_1111;
        host.rsp_ready = 1'b0;

        // Reset held two cycles with a pending request
        for (int c = 0; c < 2; c++) begin
            step();
            check("rst_req_ready", {31'd0, host.req_ready}, 32'd0);
            check("rst_en0", {31'd0, EN0}, 32'd0);
            check("rst_we0", {28'd0, WE0}, 32'd0);
            check("rst_rsp_valid", {31'd0, host.rsp_valid}, 32'd0);
            check("rst_rsp_rdata", host.rsp_rdata, 32'd0);
            check("rst_clr_busy", {31'd0, clr_busy}, 32'd0);
        end
        RST            = 1'b0;
        host.req_valid = 1'b0;
        settle();
        check("post_rst_ready", {31'd0, host.req_ready}, 32'd1);

        // Write then read back
        do_write(8'h12, 32'hDEAD_BEEF, 4'hF);
        do_read("rd12", 8'h12, 32'hDEAD_BEEF);

        // Byte lanes
        do_write(8'h03, 32'hFFFF_FFFF, 4'hF);
        do_write(8'h03, 32'h0000_00A5, 4'h1);
        do_read("rd03a", 8'h03, 32'hFFFF_FFA5);
        do_write(8'h03, 32'h1234_5678, 4'h4);
        do_read("rd03b", 8'h03, 32'hFF34_FFA5);

        // Backpressure: response held, a queued write waits for the handshake
        host.req_valid = 1'b1;
        host.req_we    = 4'h0;
        host.req_addr  = 8'h12;
        host.rsp_ready = 1'b0;
        step();
        host.req_we    = 4'hF;
        host.req_addr  = 8'h40;
        host.req_wdata = 32'h0000_CAFE;
        settle();
        for (int c = 0; c < 5; c++) begin
            step();
            check("bp_valid", {31'd0, host.rsp_valid}, 32'd1);
            check("bp_rdata", host.rsp_rdata, 32'hDEAD_BEEF);
            check("bp_req_ready", {31'd0, host.req_ready}, 32'd0);
            check("bp_en0", {31'd0, EN0}, 32'd0);
        end
        host.rsp_ready = 1'b1;
        step();
        host.rsp_ready = 1'b0;
        settle();
        check("bp_after_valid", {31'd0, host.rsp_valid}, 32'd0);
        check("bp_after_ready", {31'd0, host.req_ready}, 32'd1);
        check("bp_after_wr_en0", {31'd0, EN0}, 32'd1);
        step();
        host.req_valid = 1'b0;
        settle();
        do_read("rd40", 8'h40, 32'h0000_CAFE);

        // Reset while a response is pending
        host.req_valid = 1'b1;
        host.req_we    = 4'h0;
        host.req_addr  = 8'h12;
        step();
        host.req_valid = 1'b0;
        step();
        check("rr_valid_before", {31'd0, host.rsp_valid}, 32'd1);
        RST = 1'b1;
        settle();
        check("rr_valid_in_rst", {31'd0, host.rsp_valid}, 32'd0);
        step();
        RST = 1'b0;
        settle();
        check("rr_valid_after", {31'd0, host.rsp_valid}, 32'd0);
        check("rr_ready_after", {31'd0, host.req_ready}, 32'd1);

`ifdef RAM256_HOST_CTRL_CLR_EN
        // Full clear with a competing request
        begin
            int unsigned busy_cycles;
            int unsigned done_pulses;
            clr_start      = 1'b1;
            host.req_valid = 1'b1;
            host.req_we    = 4'hF;
            host.req_addr  = 8'h05;
            host.req_wdata = 32'h0000_0077;
            settle();
            check("clr_req_ready", {31'd0, host.req_ready}, 32'd0);
            check("clr_req_en0", {31'd0, EN0}, 32'd0);
            step();
            clr_start      = 1'b0;
            host.req_valid = 1'b0;
            settle();
            check("clr_first_en0", {31'd0, EN0}, 32'd1);
            check("clr_first_we0", {28'd0, WE0}, 32'hF);
            check("clr_first_a0", {24'd0, A0}, 32'd0);
            check("clr_first_di0", Di0, 32'h5A5A_5A5A);
            busy_cycles = 0;
            done_pulses = 0;
            for (int c = 0; c < 300 && clr_busy; c++) begin
                busy_cycles++;
                if (clr_done) done_pulses++;
                step();
            end
            check("clr_busy_cycles", busy_cycles, 32'd256);
            check("clr_done_during_busy", done_pulses, 32'd0);
            check("clr_done_pulse", {31'd0, clr_done}, 32'd1);
            step();
            check("clr_done_clear", {31'd0, clr_done}, 32'd0);
            do_read("clr_rd00", 8'h00, 32'h5A5A_5A5A);
            do_read("clr_rdff", 8'hFF, 32'h5A5A_5A5A);
        end

        // Reset in the middle of a clear
        do_write(8'h63, 32'h0BAD_0063, 4'hF);
        do_write(8'h64, 32'h0BAD_0064, 4'hF);
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        settle();
        for (int c = 0; c < 300 && A0 != 8'd100; c++) step();
        check("mid_clr_reach100", {24'd0, A0}, 32'd100);
        RST = 1'b1;
        settle();
        check("mid_clr_en0", {31'd0, EN0}, 32'd0);
        check("mid_clr_busy_rst", {31'd0, clr_busy}, 32'd0);
        step();
        RST = 1'b0;
        settle();
        check("mid_clr_busy", {31'd0, clr_busy}, 32'd0);
        check("mid_clr_done0", {31'd0, clr_done}, 32'd0);
        step();
        check("mid_clr_done1", {31'd0, clr_done}, 32'd0);
        do_read("mid_rd63", 8'h63, 32'h5A5A_5A5A);
        do_read("mid_rd64", 8'h64, 32'h0BAD_0064);
`else
        // Clear engine absent: clr_start does not block a read
        clr_start = 1'b1;
        settle();
        check("noclr_ready", {31'd0, host.req_ready}, 32'd1);
        do_read("noclr_rd12", 8'h12, 32'hDEAD_BEEF);
        clr_start = 1'b0;
        check("noclr_busy", {31'd0, clr_busy}, 32'd0);
        check("noclr_done", {31'd0, clr_done}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the bench cannot hang
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected completion");
        $fatal(1);
    end

endmodule
